// File: rtl/matrix_fb_scan.sv
// matrix_fb_scan: double-buffered 8x16 LED framebuffer with a row-multiplexed scanner.
// Game logic writes the back buffer and requests a swap. The swap is a pointer toggle
// that happens only on the row7->row0 frame boundary, so the displayed frame never tears.
// Optional feature: define MATRIX_BLANK_EN to precede every row slot with BLANK_CYC
// all-off cycles (anti-ghosting).
module matrix_fb_scan #(
    parameter int DWELL     = 64,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [3:0]  wr_col,
    input  logic        wr_data,
    input  logic        clr,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic [7:0]  MATRIX_ROW,
    output logic [15:0] MATRIX_COL
);

`ifdef MATRIX_BLANK_EN
    localparam int SLOT = BLANK_CYC + DWELL;
`else
    // Without blanking BLANK_CYC has no effect on the slot length
    localparam int SLOT = DWELL + 0 * BLANK_CYC;
`endif
    localparam int            CW       = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    row_q, row_d;
    logic          front_q, front_d;
    logic          pending_q, pending_d;
    logic          swap_done_q;
    logic          slot_end, frame_end, do_swap;
    logic          lit;
    logic [15:0]   front_row;

    logic [7:0]    mrow_q, mrow_d;
    logic [15:0]   mcol_q, mcol_d;
    logic          fstart_q, fstart_d;
    logic          ack_q, ack_d;

    // Both banks packed together for read-out; bank gi is the back buffer when front_q != gi
    logic [1:0][7:0][15:0] bank_rd;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            logic [7:0][15:0] mem_q, mem_d;

            // Back-buffer update: clear first, then the single-pixel write overrides it
            always_comb begin
                mem_d = mem_q;
                if (front_q != BANK_ID) begin
                    if (clr) begin
                        mem_d = '0;
                    end
                    if (wr_en) begin
                        mem_d[wr_row][wr_col] = wr_data;
                    end
                end
            end

            // Bank storage, cleared on reset
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_q <= '0;
                end else begin
                    mem_q <= mem_d;
                end
            end

            assign bank_rd[gi] = mem_q;
        end
    endgenerate

    // Scan counters and swap handshake next state
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (row_q == 3'd7);
        do_swap   = frame_end && pending_q;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        row_d     = slot_end ? row_q + 3'd1 : row_q;
        front_d   = front_q ^ do_swap;
        // A request seen on the swap cycle itself is absorbed by that swap;
        // a level-held request re-arms on the following cycle.
        pending_d = do_swap ? 1'b0 : (pending_q | swap_req);
    end

    // Scan state, front pointer and pending flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            row_q       <= 3'd0;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            front_q     <= front_d;
            pending_q   <= pending_d;
            swap_done_q <= do_swap;
        end
    end

    // Pin values derived from the current scan state; registered below, so every
    // output (including swap_ack) appears one cycle after the state that caused it
    always_comb begin
        front_row = bank_rd[front_q][row_q];
`ifdef MATRIX_BLANK_EN
        lit = (cnt_q >= CW'(BLANK_CYC));
`else
        lit = 1'b1;
`endif
        mrow_d   = lit ? ~(8'h01 << row_q) : 8'hFF;
        mcol_d   = lit ? ~front_row : 16'hFFFF;
        fstart_d = (row_q == 3'd0) && (cnt_q == '0);
        ack_d    = swap_done_q;
    end

    // Output registers, all pins off during reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mrow_q   <= 8'hFF;
            mcol_q   <= 16'hFFFF;
            fstart_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            mrow_q   <= mrow_d;
            mcol_q   <= mcol_d;
            fstart_q <= fstart_d;
            ack_q    <= ack_d;
        end
    end

    assign MATRIX_ROW  = mrow_q;
    assign MATRIX_COL  = mcol_q;
    assign frame_start = fstart_q;
    assign swap_ack    = ack_q;

endmodule

// File: tb/tb_matrix_fb_scan.sv
// Directed testbench for matrix_fb_scan with DWELL=4 (BLANK_CYC=2 used when
// MATRIX_BLANK_EN is defined). Checks every output cycle of each examined frame.
module tb_matrix_fb_scan;

    localparam int DW = 4;
`ifdef MATRIX_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    localparam int SLOT  = BLK + DW;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en, wr_data, clr, swap_req;
    logic [2:0]  wr_row;
    logic [3:0]  wr_col;
    logic        swap_ack, frame_start;
    logic [7:0]  MATRIX_ROW;
    logic [15:0] MATRIX_COL;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_fb_scan #(.DWELL(DW), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .clr        (clr),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_start(frame_start),
        .MATRIX_ROW (MATRIX_ROW),
        .MATRIX_COL (MATRIX_COL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] px(input int r, input int c);
        logic [127:0] v;
        v = '0;
        v[r*16 + c] = 1'b1;
        return v;
    endfunction

    // Called at the negedge where frame_start should be high; checks one whole frame
    // and returns at the negedge of the next frame's first cycle. raise/drop drive
    // swap_req so that it is sampled high exactly at the frame-boundary edge.
    task automatic check_frame(input string name, input logic [127:0] img, input logic ack,
                               input bit raise, input bit drop);
        logic [7:0]  er;
        logic [15:0] ec;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < SLOT; c++) begin
                if (c < BLK) begin
                    er = 8'hFF;
                    ec = 16'hFFFF;
                end else begin
                    er = ~(8'h01 << r);
                    ec = ~img[r*16 +: 16];
                end
                chk($sformatf("%s row%0d c%0d ROW", name, r, c), 32'(MATRIX_ROW), 32'(er));
                chk($sformatf("%s row%0d c%0d COL", name, r, c), 32'(MATRIX_COL), 32'(ec));
                chk($sformatf("%s row%0d c%0d frame_start", name, r, c), 32'(frame_start),
                    32'((r == 0 && c == 0) ? 1 : 0));
                chk($sformatf("%s row%0d c%0d swap_ack", name, r, c), 32'(swap_ack),
                    32'((r == 0 && c == 0) ? ack : 1'b0));
                if (raise && r == 7 && c == SLOT - 2) swap_req = 1'b1;
                if (drop && r == 7 && c == SLOT - 1) swap_req = 1'b0;
                @(negedge clk);
            end
        end
        $display("frame %s checked (ack=%0b)", name, ack);
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1;
        end
        if (!seen) chk({name, " frame_start timeout"}, 32'd0, 32'd1);
    endtask

    task automatic write_px(input int r, input int c, input logic d, input logic do_clr);
        wr_en   = 1'b1;
        wr_row  = 3'(r);
        wr_col  = 4'(c);
        wr_data = d;
        clr     = do_clr;
        @(negedge clk);
        wr_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 1'b0;
        clr      = 1'b0;
        swap_req = 1'b0;
        wr_row   = '0;
        wr_col   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ROW", 32'(MATRIX_ROW), 32'h00FF);
        chk("reset COL", 32'(MATRIX_COL), 32'hFFFF);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        chk("reset swap_ack", 32'(swap_ack), 32'd0);
        $display("reset state checked");
        reset_n = 1'b1;
        @(negedge clk);
        // frame_start one cycle after release, empty frames, scan order and timing
        check_frame("empty0", '0, 1'b0, 0, 0);
        check_frame("empty1", '0, 1'b0, 0, 0);

        // Single pixel (2,5) then swap: buffer B becomes front
        write_px(2, 5, 1'b1, 1'b0);
        pulse_swap();
        wait_frame("swap B");
        check_frame("B(2,5)", px(2, 5), 1'b1, 0, 0);

        // Fill back buffer A, then clr + write (0,0) in the same cycle
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                write_px(r, c, 1'b1, 1'b0);
        write_px(0, 0, 1'b1, 1'b1);
        pulse_swap();
        wait_frame("swap A");
        check_frame("A(0,0)", px(0, 0), 1'b1, 0, 0);

        // Level-held swap_req for three boundaries, then a request only at a boundary
        swap_req = 1'b1;
        wait_frame("held");
        check_frame("held1 B", px(2, 5), 1'b1, 0, 0);
        check_frame("held2 A", px(0, 0), 1'b1, 0, 1);
        check_frame("held3 B", px(2, 5), 1'b1, 1, 1);
        check_frame("no swap B", px(2, 5), 1'b0, 0, 0);
        check_frame("late A", px(0, 0), 1'b1, 0, 0);

        // Asynchronous reset mid-scan clears pins at once and empties both buffers
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset ROW", 32'(MATRIX_ROW), 32'h00FF);
        chk("midreset COL", 32'(MATRIX_COL), 32'hFFFF);
        chk("midreset frame_start", 32'(frame_start), 32'd0);
        chk("midreset swap_ack", 32'(swap_ack), 32'd0);
        $display("mid-scan reset checked");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_frame("post reset", '0, 1'b0, 0, 0);
        pulse_swap();
        wait_frame("post reset swap");
        check_frame("post reset back", '0, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
